// File: rtl/dram_burst_sched_if.sv
// ----------------------------------------------------------------------------
// dram_burst_sched_if : FIFO handshakes and DRAM burst port of dram_burst_sched
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface dram_burst_sched_if #(
  parameter int AW = 32
);
  logic          en_i;
  logic          rf_rdy_i;
  logic          rf_incr_o;
  logic          wf_val_i;
  logic          wf_incr_o;
  logic          cmd_val_o;
  logic          cmd_rdy_i;
  logic          cmd_we_o;
  logic [AW-1:0] cmd_addr_o;
  logic [7:0]    cmd_len_o;
  logic          rd_beat_i;
  logic          wr_beat_rdy_i;
  logic          wr_beat_val_o;
  logic          wr_last_o;
  logic          rd_frame_o;
  logic          wr_frame_o;
  logic          busy_o;

  modport master (
    input  en_i, rf_rdy_i, wf_val_i, cmd_rdy_i, rd_beat_i, wr_beat_rdy_i,
    output rf_incr_o, wf_incr_o, cmd_val_o, cmd_we_o, cmd_addr_o, cmd_len_o,
           wr_beat_val_o, wr_last_o, rd_frame_o, wr_frame_o, busy_o
  );

  modport slave (
    output en_i, rf_rdy_i, wf_val_i, cmd_rdy_i, rd_beat_i, wr_beat_rdy_i,
    input  rf_incr_o, wf_incr_o, cmd_val_o, cmd_we_o, cmd_addr_o, cmd_len_o,
           wr_beat_val_o, wr_last_o, rd_frame_o, wr_frame_o, busy_o
  );
endinterface

`default_nettype wire

// File: rtl/dram_burst_sched.sv
// ----------------------------------------------------------------------------
// dram_burst_sched : round-robin burst scheduler sharing one DRAM port
//                    between the read-side and write-side frame FIFOs
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dram_burst_sched #(
  parameter int            AW          = 32,
  parameter int            BURST_LEN   = 16,
  parameter int            BEAT_BYTES  = 8,
  parameter int            FRAME_BEATS = 1024,
  parameter logic [AW-1:0] RD_BASE     = '0,
  parameter logic [AW-1:0] WR_BASE     = 'h10000
) (
  input  wire logic          clk_i,
  input  wire logic          rst_i,
  dram_burst_sched_if.master bus
);

  localparam int            c_CNT_W      = $clog2(BURST_LEN);
  localparam int            c_NBURST     = FRAME_BEATS / BURST_LEN;
  localparam int            c_FCNT_W     = (c_NBURST > 1) ? $clog2(c_NBURST) : 1;
  localparam logic [c_CNT_W-1:0]  c_LAST_BEAT  = c_CNT_W'(BURST_LEN - 1);
  localparam logic [c_FCNT_W-1:0] c_LAST_BURST = c_FCNT_W'(c_NBURST - 1);
  localparam logic [AW-1:0]       c_STEP       = AW'(BURST_LEN * BEAT_BYTES);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_CMD  = 3'd1,
    S_RD_DATA = 3'd2,
    S_WR_CMD  = 3'd3,
    S_WR_DATA = 3'd4
  } state_t;

  state_t              r_state;
  logic [c_CNT_W-1:0]  r_cnt;
  logic [c_FCNT_W-1:0] r_rd_fcnt;
  logic [c_FCNT_W-1:0] r_wr_fcnt;
  logic [AW-1:0]       r_rd_addr;
  logic [AW-1:0]       r_wr_addr;
  logic                r_last_wr;
  logic                r_cmd_val;
  logic                r_cmd_we;
  logic [AW-1:0]       r_cmd_addr;
  logic                r_wr_val;
  logic                r_busy;
  logic                r_rd_frame;
  logic                r_wr_frame;

  logic w_pick_rd;
  logic w_last_beat;
  logic w_rd_xfer;
  logic w_wr_xfer;

  // Read wins a tie whenever the previous grant went to the write side.
  assign w_pick_rd   = bus.rf_rdy_i & (~bus.wf_val_i | r_last_wr);
  assign w_last_beat = (r_cnt == c_LAST_BEAT);
  assign w_rd_xfer   = (r_state == S_RD_DATA) & bus.rd_beat_i;
  assign w_wr_xfer   = (r_state == S_WR_DATA) & bus.wr_beat_rdy_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_rd_fcnt  <= '0;
      r_wr_fcnt  <= '0;
      r_rd_addr  <= RD_BASE;
      r_wr_addr  <= WR_BASE;
      r_last_wr  <= 1'b1;
      r_cmd_val  <= 1'b0;
      r_cmd_we   <= 1'b0;
      r_cmd_addr <= '0;
      r_wr_val   <= 1'b0;
      r_busy     <= 1'b0;
      r_rd_frame <= 1'b0;
      r_wr_frame <= 1'b0;
    end else begin
      r_rd_frame <= 1'b0;
      r_wr_frame <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.en_i && (bus.rf_rdy_i || bus.wf_val_i)) begin
            r_cmd_val <= 1'b1;
            r_busy    <= 1'b1;
            if (w_pick_rd) begin
              r_state    <= S_RD_CMD;
              r_last_wr  <= 1'b0;
              r_cmd_we   <= 1'b0;
              r_cmd_addr <= r_rd_addr;
            end else begin
              r_state    <= S_WR_CMD;
              r_last_wr  <= 1'b1;
              r_cmd_we   <= 1'b1;
              r_cmd_addr <= r_wr_addr;
            end
          end
        end
        S_RD_CMD: begin
          if (bus.cmd_rdy_i) begin
            r_state   <= S_RD_DATA;
            r_cmd_val <= 1'b0;
            r_cnt     <= '0;
          end
        end
        S_RD_DATA: begin
          if (bus.rd_beat_i) begin
            if (w_last_beat) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_cnt   <= '0;
              if (r_rd_fcnt == c_LAST_BURST) begin
                r_rd_addr  <= RD_BASE;
                r_rd_fcnt  <= '0;
                r_rd_frame <= 1'b1;
              end else begin
                r_rd_addr <= r_rd_addr + c_STEP;
                r_rd_fcnt <= r_rd_fcnt + 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_WR_CMD: begin
          if (bus.cmd_rdy_i) begin
            r_state   <= S_WR_DATA;
            r_cmd_val <= 1'b0;
            r_wr_val  <= 1'b1;
            r_cnt     <= '0;
          end
        end
        S_WR_DATA: begin
          if (bus.wr_beat_rdy_i) begin
            if (w_last_beat) begin
              r_state  <= S_IDLE;
              r_busy   <= 1'b0;
              r_wr_val <= 1'b0;
              r_cnt    <= '0;
              if (r_wr_fcnt == c_LAST_BURST) begin
                r_wr_addr  <= WR_BASE;
                r_wr_fcnt  <= '0;
                r_wr_frame <= 1'b1;
              end else begin
                r_wr_addr <= r_wr_addr + c_STEP;
                r_wr_fcnt <= r_wr_fcnt + 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_cmd_val <= 1'b0;
          r_wr_val  <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rf_incr_o     = w_rd_xfer;
  assign bus.wf_incr_o     = w_wr_xfer;
  assign bus.cmd_val_o     = r_cmd_val;
  assign bus.cmd_we_o      = r_cmd_we;
  assign bus.cmd_addr_o    = r_cmd_addr;
  assign bus.cmd_len_o     = 8'(BURST_LEN - 1);
  assign bus.wr_beat_val_o = r_wr_val;
  assign bus.wr_last_o     = (r_state == S_WR_DATA) & w_last_beat;
  assign bus.rd_frame_o    = r_rd_frame;
  assign bus.wr_frame_o    = r_wr_frame;
  assign bus.busy_o        = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_dram_burst_sched.sv
// ----------------------------------------------------------------------------
// tb_dram_burst_sched : directed self-checking bench for dram_burst_sched
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_dram_burst_sched;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  dram_burst_sched_if #(.AW(32)) bus ();

  dram_burst_sched dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete burst starting from IDLE with the requests already driven.
  task automatic burst(input logic we, input logic [31:0] addr, input int stall,
                       input logic toggle, input logic exp_rf, input logic exp_wf);
    int beats;
    int cyc;
    int lasts;
    int last_at;
    beats = 0; cyc = 0; lasts = 0; last_at = 0;
    bus.cmd_rdy_i = 1'b0;
    tick();
    chk("cmd_val", bus.cmd_val_o, 1);
    chk("cmd_we", bus.cmd_we_o, we);
    chk("cmd_addr", bus.cmd_addr_o, addr);
    chk("frame_single_pulse", {bus.rd_frame_o, bus.wr_frame_o}, 0);
    for (int s = 0; s < stall; s++) begin
      tick();
      chk("stall_val", bus.cmd_val_o, 1);
      chk("stall_we", bus.cmd_we_o, we);
      chk("stall_addr", bus.cmd_addr_o, addr);
    end
    bus.cmd_rdy_i = 1'b1;
    tick();
    bus.cmd_rdy_i = 1'b0;
    chk("cmd_accepted_once", bus.cmd_val_o, 0);
    while (beats < 16 && cyc < 64) begin
      if (we) bus.wr_beat_rdy_i = toggle ? ((cyc % 2) == 0) : 1'b1;
      else    bus.rd_beat_i = 1'b1;
      #1;
      if (we) begin
        chk("wf_incr_mirror", bus.wf_incr_o, bus.wr_beat_rdy_i);
        chk("wr_beat_val", bus.wr_beat_val_o, 1);
        if (bus.wf_incr_o) begin
          beats++;
          if (bus.wr_last_o) begin
            lasts++;
            last_at = beats;
          end
        end
      end else if (bus.rf_incr_o) begin
        beats++;
      end
      tick();
      cyc++;
    end
    bus.rd_beat_i     = 1'b0;
    bus.wr_beat_rdy_i = 1'b0;
    chk("beats", beats, 16);
    chk("data_cycles", cyc, toggle ? 31 : 16);
    if (we) begin
      chk("wr_last_count", lasts, 1);
      chk("wr_last_beat", last_at, 16);
    end
    chk("busy_end", bus.busy_o, 0);
    chk("rd_frame", bus.rd_frame_o, exp_rf);
    chk("wr_frame", bus.wr_frame_o, exp_wf);
  endtask

  initial begin
    rst = 1'b1;
    bus.en_i = 1'b0; bus.rf_rdy_i = 1'b0; bus.wf_val_i = 1'b0;
    bus.cmd_rdy_i = 1'b0; bus.rd_beat_i = 1'b0; bus.wr_beat_rdy_i = 1'b0;
    tick();
    tick();
    chk("rst_cmd_val", bus.cmd_val_o, 0);
    chk("rst_cmd_we", bus.cmd_we_o, 0);
    chk("rst_cmd_addr", bus.cmd_addr_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_wr_val", bus.wr_beat_val_o, 0);
    chk("rst_wr_last", bus.wr_last_o, 0);
    chk("rst_frames", {bus.rd_frame_o, bus.wr_frame_o}, 0);
    chk("cmd_len", bus.cmd_len_o, 15);

    // Requests and beats with en_i low must not start anything.
    rst = 1'b0;
    bus.rf_rdy_i = 1'b1;
    bus.rd_beat_i = 1'b1;
    tick();
    tick();
    chk("en_low_cmd_val", bus.cmd_val_o, 0);
    chk("idle_rd_beat_ignored", bus.rf_incr_o, 0);
    chk("en_low_busy", bus.busy_o, 0);
    bus.rd_beat_i = 1'b0;
    bus.en_i = 1'b1;

    burst(1'b0, 32'h0, 0, 1'b0, 1'b0, 1'b0);
    burst(1'b0, 32'h80, 0, 1'b0, 1'b0, 1'b0);

    // Both sides requesting: last grant was read, so write goes first.
    bus.wf_val_i = 1'b1;
    burst(1'b1, 32'h10000, 0, 1'b0, 1'b0, 1'b0);
    burst(1'b0, 32'h100, 0, 1'b0, 1'b0, 1'b0);
    burst(1'b1, 32'h10080, 0, 1'b0, 1'b0, 1'b0);
    burst(1'b0, 32'h180, 0, 1'b0, 1'b0, 1'b0);

    bus.wf_val_i = 1'b0;
    burst(1'b0, 32'h200, 5, 1'b0, 1'b0, 1'b0);

    bus.rf_rdy_i = 1'b0;
    bus.wf_val_i = 1'b1;
    burst(1'b1, 32'h10100, 0, 1'b1, 1'b0, 1'b0);

    // Reset while the write burst sits at beat 7.
    tick();
    chk("midrst_cmd_addr", bus.cmd_addr_o, 32'h10180);
    chk("midrst_cmd_we", bus.cmd_we_o, 1);
    bus.cmd_rdy_i = 1'b1;
    tick();
    bus.cmd_rdy_i = 1'b0;
    bus.wr_beat_rdy_i = 1'b1;
    repeat (7) tick();
    chk("midrst_pre_val", bus.wr_beat_val_o, 1);
    chk("midrst_pre_last", bus.wr_last_o, 0);
    rst = 1'b1;
    tick();
    chk("midrst_busy", bus.busy_o, 0);
    chk("midrst_wr_val", bus.wr_beat_val_o, 0);
    chk("midrst_wf_incr", bus.wf_incr_o, 0);
    chk("midrst_cmd_val", bus.cmd_val_o, 0);
    chk("midrst_wr_last", bus.wr_last_o, 0);
    chk("midrst_cmd_addr", bus.cmd_addr_o, 0);
    rst = 1'b0;
    bus.wr_beat_rdy_i = 1'b0;

    // After reset the read side wins the first tie; write restarts at its base.
    bus.rf_rdy_i = 1'b1;
    burst(1'b0, 32'h0, 0, 1'b0, 1'b0, 1'b0);
    burst(1'b1, 32'h10000, 0, 1'b0, 1'b0, 1'b0);

    bus.wf_val_i = 1'b0;
    for (int k = 1; k < 64; k++)
      burst(1'b0, 32'(k * 128), 0, 1'b0, (k == 63), 1'b0);
    burst(1'b0, 32'h0, 0, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
